pipelined_tininess_rounder: RTL and testbench

- Parametrised, elastic-pipelined rounding and tininess-detection unit for the FPU (fudian) datapath.
- Rounds a FRAC_W-bit significand fraction using round/sticky bits and the RISC-V rounding mode.
- Reports rounded fraction, carry-out, inexact, tininess-after-rounding and underflow through LAT register stages with valid/ready flow control.
- Keeps a sticky accumulator of the inexact/underflow flags for the FMA/divider writeback path.

---
 rtl/pipelined_tininess_rounder.sv | 125 ++++++++++++
 tb/tb_pipelined_tininess_rounder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_tininess_rounder.sv
// Rounds a significand fraction by RISC-V rounding mode and reports carry, inexact,
// tininess-after-rounding and underflow through an elastic LAT-stage pipeline.
module pipelined_tininess_rounder #(
    parameter int FRAC_W = 52,
    parameter int LAT    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [FRAC_W+3:0] in_sig,
    input  logic [2:0]        in_rm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_cout,
    output logic              out_inexact,
    output logic              out_tininess,
    output logic              out_underflow,
    input  logic              flags_clr,
    output logic [1:0]        acc_flags
);

    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic              cout;
        logic              inexact;
        logic              tininess;
        logic              underflow;
    } payload_t;

    logic              rnd_r;
    logic              rnd_s;
    logic              rnd_lsb;
    logic [1:0]        int_bits;
    logic [FRAC_W-1:0] frac_in;
    logic              round_up;
    logic [FRAC_W:0]   sum;
    payload_t          rnd;

    logic [LAT-1:0]    v_q, v_d;
    logic [LAT-1:0]    can_load;
    logic              all_full;
    payload_t          pay_q [LAT];
    payload_t          pay_d [LAT];
    logic [1:0]        acc_q, acc_d;
    logic              out_fire;

    assign rnd_s    = in_sig[0];
    assign rnd_r    = in_sig[1];
    assign rnd_lsb  = in_sig[2];
    assign frac_in  = in_sig[FRAC_W+1:2];
    assign int_bits = in_sig[FRAC_W+3:FRAC_W+2];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        round_up = 1'b0;
        case (in_rm)
            3'd0:    round_up = rnd_r & (rnd_s | rnd_lsb);
            3'd2:    round_up = in_sign & (rnd_r | rnd_s);
            3'd3:    round_up = ~in_sign & (rnd_r | rnd_s);
            3'd4:    round_up = rnd_r;
            default: round_up = 1'b0;
        endcase
        sum           = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
        rnd.frac      = sum[FRAC_W-1:0];
        rnd.cout      = sum[FRAC_W];
        rnd.inexact   = rnd_r | rnd_s;
        rnd.tininess  = (int_bits == 2'b00) | ((int_bits == 2'b01) & ~sum[FRAC_W]);
        rnd.underflow = rnd.tininess & rnd.inexact;
    end

    // A stage can take a new beat unless it and every stage after it are full with the output stalled.
    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            all_full = 1'b1;
            for (int j = i; j < LAT; j++) all_full = all_full & v_q[j];
            can_load[i] = ~all_full | out_ready;
        end
    end

    assign in_ready = ~flush & can_load[0];
    assign out_fire = v_q[LAT-1] & out_ready;

    always_comb begin
        v_d   = v_q;
        pay_d = pay_q;
        if (can_load[0]) v_d[0] = in_valid & ~flush;
        if (in_valid & in_ready) pay_d[0] = rnd;
        for (int i = 1; i < LAT; i++) begin
            if (can_load[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1] & ~flush) pay_d[i] = pay_q[i-1];
            end
        end
        if (flush) v_d = '0;
        acc_d = (flags_clr ? 2'b00 : acc_q)
              | (out_fire ? {pay_q[LAT-1].inexact, pay_q[LAT-1].underflow} : 2'b00);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            v_q   <= '0;
            acc_q <= '0;
            pay_q <= '{default: '0};
        end else begin
            v_q   <= v_d;
            acc_q <= acc_d;
            pay_q <= pay_d;
        end
    end

    assign out_valid     = v_q[LAT-1];
    assign out_frac      = pay_q[LAT-1].frac;
    assign out_cout      = pay_q[LAT-1].cout;
    assign out_inexact   = pay_q[LAT-1].inexact;
    assign out_tininess  = pay_q[LAT-1].tininess;
    assign out_underflow = pay_q[LAT-1].underflow;
    assign acc_flags     = acc_q;

endmodule

// File: tb/tb_pipelined_tininess_rounder.sv
// Self-checking bench: directed rounding vectors, back-pressure, flush, flags and reset,
// plus randomized traffic scored against a queue-based reference model.
module tb_pipelined_tininess_rounder;

    localparam int FW  = 52;
    localparam int LAT = 2;
    localparam int SW  = FW + 4;

    typedef struct packed {
        logic [FW-1:0] frac;
        logic          cout;
        logic          inexact;
        logic          tin;
        logic          unf;
    } res_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [SW-1:0] in_sig;
    logic [2:0]    in_rm;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_frac;
    logic          out_cout;
    logic          out_inexact;
    logic          out_tininess;
    logic          out_underflow;
    logic          flags_clr;
    logic [1:0]    acc_flags;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    logic [1:0] acc_m = 2'b00;
    bit   accepted;
    bit   last_rdy;

    pipelined_tininess_rounder #(.FRAC_W(FW), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_sig(in_sig), .in_rm(in_rm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_frac(out_frac), .out_cout(out_cout), .out_inexact(out_inexact),
        .out_tininess(out_tininess), .out_underflow(out_underflow),
        .flags_clr(flags_clr), .acc_flags(acc_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rounding: add one ulp when the mode's rule says the discarded bits round away.
    function automatic res_t ref_round(input logic sign, input logic [SW-1:0] sig, input logic [2:0] rm);
        res_t          res;
        logic [1:0]    ip;
        logic [FW-1:0] frac;
        logic [FW:0]   total;
        bit            r, s, up;
        ip    = sig[SW-1:SW-2];
        frac  = sig[SW-3:2];
        r     = sig[1];
        s     = sig[0];
        case (rm)
            3'd0:    up = r && (s || frac[0]);
            3'd2:    up = sign && (r || s);
            3'd3:    up = !sign && (r || s);
            3'd4:    up = r;
            default: up = 1'b0;
        endcase
        total       = {1'b0, frac} + (up ? 1 : 0);
        res.frac    = total[FW-1:0];
        res.cout    = total[FW];
        res.inexact = r || s;
        res.tin     = (ip == 2'd0) || (ip == 2'd1 && !res.cout);
        res.unf     = res.tin && res.inexact;
        return res;
    endfunction

    function automatic logic [SW-1:0] mk(input logic [1:0] ip, input logic [FW-1:0] f, input logic r, input logic s);
        return {ip, f, r, s};
    endfunction

    // One clock: check what the DUT shows now, advance the model, then step to the next falling edge.
    task automatic tick();
        res_t e;
        bit   fire;
        bit   exp_rdy;
        #1;
        fire     = 1'b0;
        exp_rdy  = !flush && !(exp_q.size() == LAT && !out_ready);
        last_rdy = in_ready;
        check("in_ready", in_ready, exp_rdy);
        check("acc_flags", acc_flags, acc_m);
        if (out_valid && exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            fire = 1'b1;
            check("out_frac", out_frac, e.frac);
            check("out_flags", {out_cout, out_inexact, out_tininess, out_underflow},
                  {e.cout, e.inexact, e.tin, e.unf});
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(ref_round(in_sign, in_sig, in_rm));
        acc_m = (flags_clr ? 2'b00 : acc_m) | (fire ? {e.inexact, e.unf} : 2'b00);
        if (flush) exp_q.delete();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; flush = 1'b0; flags_clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        acc_m = 2'b00;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_acc_flags", acc_flags, 2'b00);
        check("rst_out_frac", out_frac, '0);
        check("rst_out_flags", {out_cout, out_inexact, out_tininess, out_underflow}, 4'b0);
        @(negedge clock);
    endtask

    task automatic send(input logic sign, input logic [SW-1:0] sig, input logic [2:0] rm);
        in_valid = 1'b1; in_sign = sign; in_sig = sig; in_rm = rm;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) tick();
        check("send_accepted", accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        check("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic run_one(input string tag, input logic sign, input logic [SW-1:0] sig, input logic [2:0] rm,
                           input logic [FW-1:0] efrac, input logic [3:0] eflags);
        out_ready = 1'b1;
        send(sign, sig, rm);
        wait_out();
        check({tag, "_frac"}, out_frac, efrac);
        check({tag, "_flags"}, {out_cout, out_inexact, out_tininess, out_underflow}, eflags);
        tick();
    endtask

    initial begin
        logic [FW-1:0] ones;
        logic [FW-1:0] two;
        int            k;
        int            idx;
        int            lows;
        logic [SW-1:0] bp_sig [6];

        ones = '1;
        two  = FW'(2);
        in_sign = 1'b0; in_sig = '0; in_rm = 3'd0;
        do_reset();

        // Latency with no stall equals LAT.
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = 1'b0; in_sig = mk(2'b01, '0, 1'b1, 1'b0); in_rm = 3'd0;
        tick();
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("latency", k, LAT);
        tick();

        // Flags nibble is {cout, inexact, tininess, underflow}.
        run_one("rne_tie_even", 1'b0, mk(2'b01, '0, 1'b1, 1'b0), 3'd0, '0, 4'b0111);
        run_one("rne_carry", 1'b0, mk(2'b01, ones, 1'b1, 1'b0), 3'd0, '0, 4'b1100);
        run_one("rtz_carry", 1'b0, mk(2'b01, ones, 1'b1, 1'b0), 3'd1, ones, 4'b0111);
        run_one("rdn_neg", 1'b1, mk(2'b01, two, 1'b0, 1'b1), 3'd2, FW'(3), 4'b0111);
        run_one("rdn_pos", 1'b0, mk(2'b01, two, 1'b0, 1'b1), 3'd2, two, 4'b0111);
        run_one("rup_pos", 1'b0, mk(2'b01, two, 1'b0, 1'b1), 3'd3, FW'(3), 4'b0111);
        run_one("rmm_sticky", 1'b0, mk(2'b01, two, 1'b0, 1'b1), 3'd4, two, 4'b0111);
        run_one("rm6_as_rtz", 1'b0, mk(2'b01, two, 1'b0, 1'b1), 3'd6, two, 4'b0111);
        run_one("int00_tiny", 1'b0, mk(2'b00, two, 1'b0, 1'b1), 3'd1, two, 4'b0111);
        run_one("int10_normal", 1'b0, mk(2'b10, two, 1'b0, 1'b1), 3'd1, two, 4'b0100);
        run_one("rup_exact", 1'b0, mk(2'b01, two, 1'b0, 1'b0), 3'd3, two, 4'b0010);

        // Back-pressure: six back-to-back beats, consumer stalls in cycles 3..5.
        do_reset();
        for (int i = 0; i < 6; i++) bp_sig[i] = {$urandom, $urandom};
        idx = 0; lows = 0;
        for (int c = 0; c < 40 && (idx < 6 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx < 6);
            in_sign   = idx[0];
            in_sig    = bp_sig[idx % 6];
            in_rm     = 3'(idx % 5);
            tick();
            if (accepted) idx++;
            if (in_valid && !last_rdy) lows++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 6);
        check("bp_in_ready_fell", lows > 0, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Flush with two beats held and a new beat offered in the flush cycle.
        out_ready = 1'b0;
        send(1'b0, mk(2'b01, two, 1'b1, 1'b1), 3'd0);
        send(1'b1, mk(2'b00, two, 1'b0, 1'b1), 3'd2);
        flush = 1'b1; in_valid = 1'b1; in_sig = mk(2'b01, ones, 1'b1, 1'b1);
        tick();
        check("flush_not_accepted", accepted, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (4) tick();

        // A beat firing together with flags_clr stays in the accumulator.
        out_ready = 1'b0;
        send(1'b0, mk(2'b10, two, 1'b1, 1'b0), 3'd1);
        wait_out();
        flags_clr = 1'b1; out_ready = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_with_fire", acc_flags, 2'b10);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_alone", acc_flags, 2'b00);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sign   = $urandom_range(0, 1);
            in_sig    = {$urandom, $urandom};
            in_rm     = $urandom_range(0, 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            flags_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        check("rand_drained", exp_q.size(), 0);

        // Reset with beats in flight discards them.
        out_ready = 1'b0;
        send(1'b0, mk(2'b01, two, 1'b1, 1'b0), 3'd0);
        send(1'b0, mk(2'b00, ones, 1'b0, 1'b1), 3'd3);
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
